// File: rtl/sme_feeder.sv
// sme_feeder
//   Buffers one record (string or pattern) from a byte stream, then replays
//   it to the string-match engine one character per cycle with the matching
//   qualifier. After a pattern it waits for the engine result, with a
//   256-cycle watchdog, and reports it as a single-cycle result pulse.
//
// Ports
//   clk, reset                  clock (rising edge), synchronous active-high reset
//   in_valid/in_ready           upstream byte handshake (in_ready = LOAD state)
//   in_data, in_kind, in_last   record byte, record type (0 string, 1 pattern),
//                               final-byte marker
//   chardata                    character to the match engine
//   isstring, ispattern         character qualifiers, never both high
//   sme_valid, sme_match,
//   sme_match_index             engine result, honoured only while waiting
//   res_valid                   one-cycle result pulse
//   res_match, res_index,
//   res_timeout                 result fields, held between pulses
//   ovf_err                     sticky: a record exceeded its capacity
module sme_feeder (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       in_kind,
    input  logic       in_last,
    output logic       in_ready,
    output logic [7:0] chardata,
    output logic       isstring,
    output logic       ispattern,
    input  logic       sme_valid,
    input  logic       sme_match,
    input  logic [4:0] sme_match_index,
    output logic       res_valid,
    output logic       res_match,
    output logic [4:0] res_index,
    output logic       res_timeout,
    output logic       ovf_err
);

    typedef enum logic [1:0] {
        LOAD,
        SEND,
        WAIT
    } state_t;

    state_t     state;
    state_t     state_nxt;

    logic [7:0] char_buf [32];
    logic [5:0] wr_cnt;
    logic [5:0] rd_ptr;
    logic [5:0] send_len;
    logic       kind_q;
    logic [8:0] wd_cnt;

    logic       accept;
    logic       cur_kind;
    logic [5:0] limit;
    logic       room;
    logic       send_done;
    logic       wd_expire;

    assign in_ready = (state == LOAD);

    always_comb begin
        accept    = in_valid && (state == LOAD);
        // Record type is taken from the first byte only; later bytes use the latched kind.
        cur_kind  = (wr_cnt == '0) ? in_kind : kind_q;
        limit     = cur_kind ? 6'd8 : 6'd32;
        room      = (wr_cnt < limit);
        send_done = (rd_ptr >= send_len);
        wd_expire = (wd_cnt == 9'd255);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD: if (accept && in_last) state_nxt = SEND;
            SEND: if (send_done) state_nxt = kind_q ? WAIT : LOAD;
            WAIT: if (sme_valid || wd_expire) state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= LOAD;
        else       state <= state_nxt;
    end

    // Record storage needs no reset: contents are only read after being written.
    always_ff @(posedge clk) begin
        if (accept && room) char_buf[wr_cnt[4:0]] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_cnt      <= '0;
            rd_ptr      <= '0;
            send_len    <= '0;
            kind_q      <= 1'b0;
            wd_cnt      <= '0;
            chardata    <= '0;
            isstring    <= 1'b0;
            ispattern   <= 1'b0;
            res_valid   <= 1'b0;
            res_match   <= 1'b0;
            res_index   <= '0;
            res_timeout <= 1'b0;
            ovf_err     <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            case (state)
                LOAD: begin
                    if (accept) begin
                        if (wr_cnt == '0) kind_q <= in_kind;
                        if (room) wr_cnt <= wr_cnt + 6'd1;
                        else      ovf_err <= 1'b1;
                        if (in_last) begin
                            wr_cnt    <= '0;
                            send_len  <= room ? wr_cnt + 6'd1 : wr_cnt;
                            rd_ptr    <= 6'd1;
                            // Character 0 goes out now; a 1-byte record is not in the buffer yet.
                            chardata  <= (wr_cnt == '0) ? in_data : char_buf[0];
                            isstring  <= ~cur_kind;
                            ispattern <= cur_kind;
                        end
                    end
                end
                SEND: begin
                    if (send_done) begin
                        isstring  <= 1'b0;
                        ispattern <= 1'b0;
                        wd_cnt    <= '0;
                    end else begin
                        chardata <= char_buf[rd_ptr[4:0]];
                        rd_ptr   <= rd_ptr + 6'd1;
                    end
                end
                WAIT: begin
                    if (sme_valid) begin
                        res_valid   <= 1'b1;
                        res_match   <= sme_match;
                        res_index   <= sme_match_index;
                        res_timeout <= 1'b0;
                    end else if (wd_expire) begin
                        res_valid   <= 1'b1;
                        res_match   <= 1'b0;
                        res_index   <= '0;
                        res_timeout <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + 9'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sme_feeder.sv
// Testbench for sme_feeder: scoreboarded character stream, run lengths and
// engine results, plus per-scenario timing checks.
module tb_sme_feeder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_kind = 1'b0;
    logic       in_last = 1'b0;
    logic       in_ready;
    logic [7:0] chardata;
    logic       isstring;
    logic       ispattern;
    logic       sme_valid = 1'b0;
    logic       sme_match = 1'b0;
    logic [4:0] sme_match_index = '0;
    logic       res_valid;
    logic       res_match;
    logic [4:0] res_index;
    logic       res_timeout;
    logic       ovf_err;

    int checks = 0;
    int errors = 0;

    logic [8:0] exp_chars [$];   // {pattern_kind, char}
    int         exp_runs  [$];   // qualifier run lengths
    logic [6:0] exp_res   [$];   // {match, index, timeout}

    bit         mon_en = 1'b0;
    int         mon_run = 0;
    logic [8:0] mon_c;
    logic [6:0] mon_r;
    int         mon_len;
    bit         b2b_done = 1'b0;

    sme_feeder dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_data         (in_data),
        .in_kind         (in_kind),
        .in_last         (in_last),
        .in_ready        (in_ready),
        .chardata        (chardata),
        .isstring        (isstring),
        .ispattern       (ispattern),
        .sme_valid       (sme_valid),
        .sme_match       (sme_match),
        .sme_match_index (sme_match_index),
        .res_valid       (res_valid),
        .res_match       (res_match),
        .res_index       (res_index),
        .res_timeout     (res_timeout),
        .ovf_err         (ovf_err)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: pops expected characters, run lengths and results.
    always @(negedge clk) begin
        if (!mon_en) begin
            mon_run = 0;
        end else begin
            if (isstring && ispattern) begin
                checks++; errors++;
                $display("FAIL qual_exclusive got both high need at most one");
            end
            if (isstring || ispattern) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL ready_in_send got %b need 0", in_ready);
                end
                checks++;
                if (exp_chars.size() == 0) begin
                    errors++;
                    $display("FAIL char_unexpected got kind=%b data=%h need no qualifier", ispattern, chardata);
                end else begin
                    mon_c = exp_chars.pop_front();
                    if ({ispattern, chardata} !== mon_c) begin
                        errors++;
                        $display("FAIL char_stream got kind=%b data=%h need kind=%b data=%h",
                                 ispattern, chardata, mon_c[8], mon_c[7:0]);
                    end
                end
                mon_run++;
            end else if (mon_run > 0) begin
                checks++;
                mon_len = (exp_runs.size() != 0) ? exp_runs.pop_front() : -1;
                if (mon_run != mon_len) begin
                    errors++;
                    $display("FAIL run_length got %0d need %0d", mon_run, mon_len);
                end
                mon_run = 0;
            end
            if (res_valid) begin
                checks++;
                if (exp_res.size() == 0) begin
                    errors++;
                    $display("FAIL res_unexpected got res_valid=1 need 0");
                end else begin
                    mon_r = exp_res.pop_front();
                    if ({res_match, res_index, res_timeout} !== mon_r) begin
                        errors++;
                        $display("FAIL res_fields got m=%b i=%0d t=%b need m=%b i=%0d t=%b",
                                 res_match, res_index, res_timeout, mon_r[6], mon_r[5:1], mon_r[0]);
                    end
                end
            end
        end
    end

    // Drives one record byte by byte (kind flipped after the first byte),
    // then checks the first character appears the cycle after in_last is taken.
    task automatic send_rec(input bit kind, input int len, input logic [7:0] seed, input bit hold);
        int         i;
        int         guard;
        int         lim;
        bit         rdy;
        logic [7:0] d;
        i = 0;
        guard = 0;
        lim = kind ? 8 : 32;
        exp_runs.push_back((len < lim) ? len : lim);
        while (i < len) begin
            @(negedge clk);
            d        = seed + 8'(i);
            in_valid = 1'b1;
            in_data  = d;
            in_kind  = (i == 0) ? kind : ~kind;
            in_last  = (i == len - 1);
            rdy      = in_ready;
            @(posedge clk);
            if (rdy) begin
                if (i < lim) exp_chars.push_back({kind, d});
                i++;
            end else begin
                guard++;
                if (guard > 600) begin
                    checks++; errors++;
                    $display("FAIL send_accept got in_ready=0 for %0d cycles need 1", guard);
                    break;
                end
            end
        end
        @(negedge clk);
        checks++;
        if ((kind ? ispattern : isstring) !== 1'b1 || chardata !== seed) begin
            errors++;
            $display("FAIL first_char_latency got q=%b data=%h need q=1 data=%h",
                     kind ? ispattern : isstring, chardata, seed);
        end
        if (!hold) begin
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    // Returns at the first negedge where no qualifier is high.
    task automatic wait_fall(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (!(isstring || ispattern)) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b need 1", in_ready); end
        checks++;
        if ({isstring, ispattern} !== 2'b00) begin
            errors++; $display("FAIL reset_qual got %b%b need 00", isstring, ispattern);
        end
        checks++;
        if (chardata !== 8'h00) begin errors++; $display("FAIL reset_chardata got %h need 00", chardata); end
        checks++;
        if ({res_valid, res_match, res_index, res_timeout} !== 8'h00) begin
            errors++;
            $display("FAIL reset_res got v=%b m=%b i=%0d t=%b need all 0", res_valid, res_match, res_index, res_timeout);
        end
        checks++;
        if (ovf_err !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b need 0", ovf_err); end
        reset = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic test_string_abc;
        bit ok;
        send_rec(1'b0, 3, 8'h61, 1'b0);
        wait_fall(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL abc_fall got qualifier stuck need low"); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL abc_ready got %b need 1", in_ready); end
        checks++;
        if (chardata !== 8'h63) begin errors++; $display("FAIL abc_hold got %h need 63", chardata); end
        checks++;
        if (ovf_err !== 1'b0) begin errors++; $display("FAIL abc_ovf got %b need 0", ovf_err); end
    endtask

    task automatic test_pattern_match;
        bit ok;
        exp_res.push_back({1'b1, 5'd1, 1'b0});
        send_rec(1'b1, 1, 8'h62, 1'b0);
        wait_fall(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL pat_fall got qualifier stuck need low"); end
        repeat (4) @(negedge clk);
        sme_match = 1'b1;
        sme_match_index = 5'd1;
        sme_valid = 1'b1;
        @(negedge clk);
        sme_valid = 1'b0;
        checks++;
        if ({res_valid, res_match, res_index, res_timeout} !== {1'b1, 1'b1, 5'd1, 1'b0}) begin
            errors++;
            $display("FAIL pat_result got v=%b m=%b i=%0d t=%b need v=1 m=1 i=1 t=0",
                     res_valid, res_match, res_index, res_timeout);
        end
        sme_match = 1'b0;
        sme_match_index = 5'd0;
        @(negedge clk);
        checks++;
        if ({res_valid, res_match, res_index, res_timeout} !== {1'b0, 1'b1, 5'd1, 1'b0}) begin
            errors++;
            $display("FAIL pat_hold got v=%b m=%b i=%0d t=%b need v=0 m=1 i=1 t=0",
                     res_valid, res_match, res_index, res_timeout);
        end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL pat_ready got %b need 1", in_ready); end
    endtask

    task automatic test_overflow;
        bit ok;
        send_rec(1'b0, 40, 8'h20, 1'b0);
        wait_fall(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL ovf_str_fall got qualifier stuck need low"); end
        checks++;
        if (chardata !== 8'h3F) begin errors++; $display("FAIL ovf_str_last got %h need 3f", chardata); end
        checks++;
        if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b need 1", ovf_err); end
        exp_res.push_back({1'b0, 5'd5, 1'b0});
        send_rec(1'b1, 10, 8'h80, 1'b0);
        wait_fall(ok);
        checks++;
        if (chardata !== 8'h87) begin errors++; $display("FAIL ovf_pat_last got %h need 87", chardata); end
        sme_match = 1'b0;
        sme_match_index = 5'd5;
        sme_valid = 1'b1;
        @(negedge clk);
        sme_valid = 1'b0;
        sme_match_index = 5'd0;
        checks++;
        if (res_valid !== 1'b1 || res_index !== 5'd5) begin
            errors++; $display("FAIL ovf_pat_result got v=%b i=%0d need v=1 i=5", res_valid, res_index);
        end
    endtask

    task automatic test_timeout;
        bit ok;
        int hit;
        hit = -1;
        exp_res.push_back({1'b0, 5'd0, 1'b1});
        send_rec(1'b1, 3, 8'h41, 1'b0);
        wait_fall(ok);
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk);
            if (res_valid) begin
                hit = n;
                break;
            end
        end
        checks++;
        if (hit != 256) begin errors++; $display("FAIL timeout_latency got %0d need 256", hit); end
        checks++;
        if (res_timeout !== 1'b1 || in_ready !== 1'b1) begin
            errors++; $display("FAIL timeout_state got t=%b rdy=%b need t=1 rdy=1", res_timeout, in_ready);
        end
    endtask

    task automatic test_reset_mid_send;
        bit ok;
        int seen;
        checks++;
        if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b need 1", ovf_err); end
        send_rec(1'b0, 20, 8'h10, 1'b0);
        repeat (3) @(negedge clk);
        mon_en = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({isstring, ispattern} !== 2'b00 || chardata !== 8'h00) begin
            errors++;
            $display("FAIL rst_send_qual got q=%b%b data=%h need q=00 data=00", isstring, ispattern, chardata);
        end
        checks++;
        if (ovf_err !== 1'b0 || in_ready !== 1'b1 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_send_state got ovf=%b rdy=%b rv=%b need ovf=0 rdy=1 rv=0", ovf_err, in_ready, res_valid);
        end
        exp_chars.delete();
        exp_runs.delete();
        exp_res.delete();
        @(negedge clk);
        mon_run = 0;
        mon_en = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (res_valid || isstring) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL rst_send_quiet got %0d activity cycles need 0", seen); end
        send_rec(1'b0, 2, 8'h55, 1'b0);
        wait_fall(ok);
        checks++;
        if (!ok || chardata !== 8'h56) begin
            errors++; $display("FAIL rst_fresh got ok=%b data=%h need ok=1 data=56", ok, chardata);
        end
    endtask

    task automatic test_back_to_back;
        bit ok;
        int seen;
        seen = 0;
        ok = 1'b0;
        b2b_done = 1'b0;
        fork
            begin
                send_rec(1'b0, 5, 8'hA0, 1'b1);
                send_rec(1'b0, 4, 8'hB0, 1'b1);
                send_rec(1'b0, 3, 8'hC0, 1'b0);
                wait_fall(ok);
                b2b_done = 1'b1;
            end
            begin
                for (int k = 0; k < 200 && !b2b_done; k++) begin
                    @(negedge clk);
                    sme_valid = (k % 3 == 0);
                    if (res_valid) seen++;
                end
                sme_valid = 1'b0;
            end
        join
        checks++;
        if (!ok) begin errors++; $display("FAIL b2b_fall got qualifier stuck need low"); end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL b2b_ignore got %0d res pulses need 0", seen); end
        checks++;
        if (exp_chars.size() != 0 || exp_runs.size() != 0) begin
            errors++;
            $display("FAIL b2b_drain got %0d chars %0d runs left need 0 0", exp_chars.size(), exp_runs.size());
        end
    endtask

    initial begin
        test_reset();
        test_string_abc();
        test_pattern_match();
        test_overflow();
        test_timeout();
        test_reset_mid_send();
        test_back_to_back();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_res.size() != 0) begin
            errors++; $display("FAIL res_drain got %0d results pending need 0", exp_res.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout got no finish need finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sme_feeder.md
SME_FEEDER -- requirements
Module: sme_feeder

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all logic on rising edge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: in_valid  in  1  upstream byte valid.
REQ-004 SHALL have ports: in_data  in  8  record character.
REQ-005 SHALL have ports: in_kind  in  1  record type, 0 = string, 1 = pattern; sampled on the first byte of each record.
REQ-006 SHALL have ports: in_last  in  1  final byte of the record.
REQ-007 SHALL have ports: in_ready  out  1  byte accepted when in_valid and in_ready are both high.
REQ-008 SHALL have ports: chardata  out  8  character to the match engine.
REQ-009 SHALL have ports: isstring, ispattern  out  1 each  qualifiers to the match engine.
REQ-010 SHALL have ports: sme_valid  in  1, sme_match  in  1, sme_match_index  in  5  engine result.
REQ-011 SHALL have ports: res_valid  out  1, res_match  out  1, res_index  out  5, res_timeout  out  1, ovf_err  out  1.

Function
REQ-012 SHALL implement FSM states LOAD, SEND, WAIT; reset state LOAD.
REQ-013 LOAD: in_ready = 1; accepted bytes written to a 32x8 buffer at the write count; count increments per accepted byte.
REQ-014 Capacity limits: string 32 bytes, pattern 8 bytes; bytes beyond the limit are accepted and discarded, and ovf_err sets sticky until reset.
REQ-015 Accepting a byte with in_last = 1 in cycle t SHALL move to SEND; the first character appears on chardata with its qualifier high in cycle t+1.
REQ-016 SEND: in_ready = 0; one buffered character per cycle on consecutive cycles with no gaps; isstring high for string records, ispattern high for pattern records; never both.
REQ-017 In the cycle after the last character, the qualifier SHALL be low; string record -> LOAD; pattern record -> WAIT.
REQ-018 A record of length L SHALL hold its qualifier high for exactly min(L, limit) cycles.
REQ-019 WAIT: in_ready = 0; a 9-bit watchdog counts cycles from WAIT entry.
REQ-020 sme_valid high in WAIT cycle t SHALL give res_valid = 1 for exactly cycle t+1, with res_match = sme_match, res_index = sme_match_index, res_timeout = 0; FSM -> LOAD.
REQ-021 Watchdog reaching 256 without sme_valid SHALL give one res_valid pulse with res_timeout = 1, res_match = 0, res_index = 0; FSM -> LOAD.
REQ-022 sme_valid outside WAIT SHALL be ignored: no res_valid.
REQ-023 res_match, res_index, and res_timeout SHALL hold their last values between pulses.
REQ-024 chardata SHALL hold its last driven value when no qualifier is high.
REQ-025 A pattern record arriving with no prior string SHALL still be forwarded unchanged.
REQ-026 A new string record SHALL replace the engine string; the feeder stores no string history.
REQ-027 in_kind changes mid-record SHALL be ignored.
REQ-028 All outputs SHALL be registered, except in_ready, which is decoded from state.

Reset
REQ-029 reset high at a clock edge SHALL force LOAD, clear the buffer count, clear the watchdog, and clear ovf_err.
REQ-030 reset SHALL drive isstring = ispattern = 0, chardata = 0, and res_valid = res_match = res_timeout = 0, res_index = 0, in_ready = 1 from the next cycle.
REQ-031 reset mid-SEND or mid-WAIT SHALL abort the record with no res_valid pulse; the first post-reset record SHALL start a fresh count.

Verification
REQ-032 String "abc" (3 bytes, in_last on 'c') -> isstring high 3 consecutive cycles starting one cycle after 'c' is accepted; chardata 0x61, 0x62, 0x63; ispattern 0; then in_ready = 1.
REQ-033 Pattern "b" after the string; model asserts sme_valid with match = 1, index = 1 four cycles after ispattern falls -> one res_valid pulse with res_match = 1, res_index = 1, res_timeout = 0.
REQ-034 40-byte string -> isstring exactly 32 cycles, last char = byte 32, ovf_err = 1; 10-byte pattern -> ispattern exactly 8 cycles.
REQ-035 Pattern with model never asserting sme_valid -> res_valid with res_timeout = 1 exactly 256 cycles after WAIT entry; FSM back in LOAD.
REQ-036 Reset asserted during SEND of a 20-byte string -> isstring low the following cycle, no res_valid, ovf_err = 0; next 2-byte string streams exactly 2 characters.
REQ-037 sme_valid pulsed during LOAD and SEND -> no res_valid; in_valid held high continuously -> in_ready low throughout SEND/WAIT, and no bytes are lost or duplicated.
